// File: rtl/mux_stream_n.sv
// mux_stream_n: N:1 streaming multiplexer with valid/ready handshakes.
// Selection is either driven by an external channel index (MODE=0) or by
// fair round-robin arbitration (MODE=1). The chosen beat is captured in a
// single output register together with the index of its source channel.
module mux_stream_n #(
  parameter  int NUM_CH = 8,
  parameter  int DATA_W = 8,
  parameter  int MODE   = 0,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic                can_load;
  logic                accept;
  logic                gnt_any;
  logic [SEL_W-1:0]    gnt_idx;
  logic [NUM_CH-1:0]   grant;
  logic [DATA_W-1:0]   mux_data;
  logic [SEL_W-1:0]    rr_ptr;

  logic                found_hi;
  logic [SEL_W-1:0]    idx_hi;
  logic                found_lo;
  logic [SEL_W-1:0]    idx_lo;

  logic [DATA_W-1:0]   data_p0;
  logic [SEL_W-1:0]    ch_p0;
  logic                vld_p0;

  // Pointer advance after a grant to channel g; wraps at NUM_CH, which
  // matters when NUM_CH is not a power of two.
  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] g);
    if (int'(g) == NUM_CH - 1) return '0;
    return g + SEL_W'(1);
  endfunction

  // Round-robin search: the lowest valid channel at or above rr_ptr wins,
  // otherwise the lowest valid channel overall (the wrap-around part).
  always_comb begin
    found_hi = 1'b0;
    idx_hi   = '0;
    found_lo = 1'b0;
    idx_lo   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        found_lo = 1'b1;
        idx_lo   = SEL_W'(i);
        if (i >= int'(rr_ptr)) begin
          found_hi = 1'b1;
          idx_hi   = SEL_W'(i);
        end
      end
    end
  end

  // Grant selection: one-hot or empty; an out-of-range sel grants nothing.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (MODE == 0) begin
      if (int'(sel) < NUM_CH) begin
        gnt_any = 1'b1;
        gnt_idx = sel;
      end
    end else begin
      gnt_any = found_lo;
      gnt_idx = found_hi ? idx_hi : idx_lo;
    end
    grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      grant[i] = gnt_any && (int'(gnt_idx) == i);
    end
  end

  // Data mux driven by the one-hot grant.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) mux_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  // Ready is offered to the granted channel even if it is not valid (MODE=0),
  // so producers never need in_valid to see ready.
  assign can_load = ~vld_p0 | out_ready;
  assign in_ready = grant & {NUM_CH{can_load & ~rst}};
  assign accept   = (|(grant & in_valid)) & can_load & ~rst;

  // ---- stage p0: output register (beat, source index, valid) ----
  // Loads on acceptance, empties when drained with nothing new arriving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      ch_p0   <= '0;
    end else if (accept) begin
      vld_p0  <= 1'b1;
      data_p0 <= mux_data;
      ch_p0   <= gnt_idx;
    end else if (out_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  // Round-robin pointer moves just past the channel that was served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (MODE == 1 && accept) begin
      rr_ptr <= next_ptr(gnt_idx);
    end
  end

  assign out_data  = data_p0;
  assign out_ch    = ch_p0;
  assign out_valid = vld_p0;

endmodule

// File: tb/tb_mux_stream_n.sv
// Directed bench for mux_stream_n: select-driven instances with 8 and 6
// channels and a 5-channel round-robin instance share clock and reset.
module tb_mux_stream_n;

  logic clk;
  logic rst;

  logic [63:0] in_data8;
  logic [7:0]  in_valid8, in_ready8;
  logic [2:0]  sel8, out_ch8;
  logic [7:0]  out_data8;
  logic        out_valid8, out_ready8;

  logic [47:0] in_data6;
  logic [5:0]  in_valid6, in_ready6;
  logic [2:0]  sel6, out_ch6;
  logic [7:0]  out_data6;
  logic        out_valid6, out_ready6;

  logic [39:0] in_data5;
  logic [4:0]  in_valid5, in_ready5;
  logic [2:0]  sel5, out_ch5;
  logic [7:0]  out_data5;
  logic        out_valid5, out_ready5;

  int n_chk;
  int n_fail;

  mux_stream_n #(.NUM_CH(8), .DATA_W(8), .MODE(0)) u8 (
    .clk(clk), .rst(rst), .in_data(in_data8), .in_valid(in_valid8),
    .in_ready(in_ready8), .sel(sel8), .out_data(out_data8), .out_ch(out_ch8),
    .out_valid(out_valid8), .out_ready(out_ready8));

  mux_stream_n #(.NUM_CH(6), .DATA_W(8), .MODE(0)) u6 (
    .clk(clk), .rst(rst), .in_data(in_data6), .in_valid(in_valid6),
    .in_ready(in_ready6), .sel(sel6), .out_data(out_data6), .out_ch(out_ch6),
    .out_valid(out_valid6), .out_ready(out_ready6));

  mux_stream_n #(.NUM_CH(5), .DATA_W(8), .MODE(1)) u5 (
    .clk(clk), .rst(rst), .in_data(in_data5), .in_valid(in_valid5),
    .in_ready(in_ready5), .sel(sel5), .out_data(out_data5), .out_ch(out_ch5),
    .out_valid(out_valid5), .out_ready(out_ready5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seq1[7];
    int seq2[4];
    seq1 = '{0, 1, 2, 3, 4, 0, 1};
    seq2 = '{3, 1, 3, 1};
    n_chk  = 0;
    n_fail = 0;

    rst = 1'b1;
    in_valid8 = 8'hFF; sel8 = 3'd0; out_ready8 = 1'b1;
    in_valid6 = 6'h00; sel6 = 3'd0; out_ready6 = 1'b1;
    in_valid5 = 5'h00; sel5 = 3'd0; out_ready5 = 1'b1;
    for (int i = 0; i < 8; i++) in_data8[i*8 +: 8] = 8'hA0 + 8'(i);
    for (int i = 0; i < 6; i++) in_data6[i*8 +: 8] = 8'hB0 + 8'(i);
    for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'hC0 + 8'(i);

    // reset held with every channel valid and the consumer ready
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_valid", 32'(out_valid8), 32'h0);
      chk("rst_data",  32'(out_data8),  32'h0);
      chk("rst_ch",    32'(out_ch8),    32'h0);
      chk("rst_ready", 32'(in_ready8),  32'h0);
    end

    // release between edges; first beat one cycle later
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(in_ready8), 32'h01);
    step();
    chk("first_valid", 32'(out_valid8), 32'h1);
    chk("first_data",  32'(out_data8),  32'hA0);
    chk("first_ch",    32'(out_ch8),    32'h0);

    // select sweep
    for (int s = 1; s < 8; s++) begin
      sel8 = 3'(s);
      #1;
      chk("sweep_ready", 32'(in_ready8), 32'(1 << s));
      step();
      chk("sweep_data", 32'(out_data8), 32'hA0 + 32'(s));
      chk("sweep_ch",   32'(out_ch8),   32'(s));
    end
    in_valid8 = 8'h00;
    step();
    chk("drain_valid", 32'(out_valid8), 32'h0);
    chk("drain_hold",  32'(out_data8),  32'hA7);

    // six channels: highest legal select, then out-of-range select
    in_valid6 = 6'h3F; sel6 = 3'd5;
    step();
    chk("n6_ch",   32'(out_ch6),   32'h5);
    chk("n6_data", 32'(out_data6), 32'hB5);
    sel6 = 3'd7;
    #1;
    chk("n6_oor_ready", 32'(in_ready6), 32'h0);
    step();
    chk("n6_oor_valid", 32'(out_valid6), 32'h0);
    chk("n6_oor_hold",  32'(out_data6),  32'hB5);

    // backpressure on channel 3
    in_valid8 = 8'h08; sel8 = 3'd3; out_ready8 = 1'b0;
    #1;
    chk("bp_empty_ready", 32'(in_ready8), 32'h08);
    step();
    chk("bp_load_valid", 32'(out_valid8), 32'h1);
    chk("bp_load_data",  32'(out_data8),  32'hA3);
    in_data8[24 +: 8] = 8'h5C;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ready", 32'(in_ready8), 32'h0);
      step();
      chk("bp_hold_data",  32'(out_data8),  32'hA3);
      chk("bp_hold_valid", 32'(out_valid8), 32'h1);
    end
    out_ready8 = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready8), 32'h08);
    step();
    chk("bp_next_data",  32'(out_data8),  32'h5C);
    chk("bp_next_valid", 32'(out_valid8), 32'h1);
    in_valid8 = 8'h00;
    step();
    chk("bp_drain", 32'(out_valid8), 32'h0);

    // round-robin, all five channels valid
    in_valid5 = 5'h1F;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("rr_all_ch",   32'(out_ch5),   32'(seq1[k]));
      chk("rr_all_data", 32'(out_data5), 32'hC0 + 32'(seq1[k]));
    end
    // only channels 1 and 3; pointer sits at 2 here
    in_valid5 = 5'b01010;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_pair_ch", 32'(out_ch5), 32'(seq2[k]));
    end
    // serve channel 3 to park the pointer at 4
    in_valid5 = 5'b01000;
    step();
    chk("rr_park_ch", 32'(out_ch5), 32'h3);

    // sparse: only channel 2, out_ready toggling 1,0,1
    in_valid5 = 5'b00100;
    in_data5[16 +: 8] = 8'hD0;
    #1;
    chk("sp_wrap_ready", 32'(in_ready5), 32'h04);
    step();
    chk("sp_ch0",   32'(out_ch5),   32'h2);
    chk("sp_data0", 32'(out_data5), 32'hD0);
    in_data5[16 +: 8] = 8'hD1;
    out_ready5 = 1'b0;
    #1;
    chk("sp_stall_ready", 32'(in_ready5), 32'h0);
    step();
    chk("sp_stall_data",  32'(out_data5),  32'hD0);
    chk("sp_stall_valid", 32'(out_valid5), 32'h1);
    out_ready5 = 1'b1;
    #1;
    chk("sp_go_ready", 32'(in_ready5), 32'h04);
    step();
    chk("sp_data1", 32'(out_data5), 32'hD1);
    chk("sp_ch1",   32'(out_ch5),   32'h2);
    in_valid5 = 5'h00;
    step();
    chk("sp_drain", 32'(out_valid5), 32'h0);
    in_valid5 = 5'h1F;
    #1;
    chk("sp_ptr3_ready", 32'(in_ready5), 32'h08);
    step();
    chk("sp_ptr3_ch",    32'(out_ch5),    32'h3);
    chk("sp_ptr3_valid", 32'(out_valid5), 32'h1);

    // asynchronous reset between edges while a beat is held
    out_ready5 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid5), 32'h0);
    chk("arst_data",  32'(out_data5),  32'h0);
    chk("arst_ready", 32'(in_ready5),  32'h0);
    #2;
    rst = 1'b0;
    out_ready5 = 1'b1;
    #1;
    chk("arst_ptr_ready", 32'(in_ready5), 32'h01);
    step();
    chk("arst_next_ch",   32'(out_ch5),   32'h0);
    chk("arst_next_data", 32'(out_data5), 32'hC0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
